// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: drives PC enable/select, the instruction
// memory req/ack handshake, fetch-register enable/flush, skid capture and halt.
module fetch_ctrl #(
  parameter int WORD         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_WAIT     = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt,
  input  logic            stallD,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  input  logic            imem_ack,
  output logic            imem_req,
  output logic            pc_en,
  output logic            pc_sel,
  output logic [WORD-1:0] target_pc,
  output logic            skid_load,
  output logic            skid_use,
  output logic            fetch_en,
  output logic            fetch_flush,
  output logic [2:0]      state,
  output logic            halted,
  output logic            timeout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t          state_reg,   state_next;
  logic [7:0]      wait_reg,    wait_next;
  logic [2:0]      flush_reg,   flush_next;
  logic [WORD-1:0] target_reg,  target_next;
  logic            timeout_reg, timeout_next;
  logic [7:0]      wait_inc;

  // Saturating increment so a huge MAX_WAIT can never wrap the counter.
  assign wait_inc = (wait_reg == 8'hFF) ? wait_reg : wait_reg + 8'd1;

  always_comb begin
    state_next   = state_reg;
    wait_next    = wait_reg;
    flush_next   = flush_reg;
    target_next  = target_reg;
    timeout_next = timeout_reg;
    imem_req     = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = 1'b0;
    skid_load    = 1'b0;
    skid_use     = 1'b0;
    fetch_en     = 1'b0;
    fetch_flush  = 1'b0;
    halted       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH;
      end

      FETCH, HOLD, FLUSH: begin
        if (redirect) begin
          // Taken branch overrides everything; any ack this cycle is dropped.
          target_next = redirect_pc;
          pc_en       = 1'b1;
          pc_sel      = 1'b1;
          fetch_flush = 1'b1;
          flush_next  = FLUSH_INIT;
          wait_next   = 8'd0;
          state_next  = FLUSH;
        end else if (state_reg == FETCH) begin
          imem_req = 1'b1;
          if (!imem_ack && (wait_inc >= MAX_WAIT_C)) begin
            wait_next    = wait_inc;
            timeout_next = 1'b1;
            state_next   = HALT;
          end else if (halt) begin
            state_next = HALT;
          end else if (imem_ack) begin
            wait_next = 8'd0;
            pc_en     = 1'b1;
            if (stallD) begin
              skid_load  = 1'b1;
              state_next = HOLD;
            end else begin
              fetch_en = 1'b1;
            end
          end else begin
            wait_next = wait_inc;
          end
        end else if (state_reg == HOLD) begin
          skid_use = 1'b1;
          if (halt) begin
            state_next = HALT;
          end else if (!stallD) begin
            fetch_en   = 1'b1;
            state_next = FETCH;
          end
        end else begin
          fetch_flush = 1'b1;
          if (halt) begin
            state_next = HALT;
          end else if (flush_reg <= 3'd1) begin
            flush_next = 3'd0;
            state_next = FETCH;
          end else begin
            flush_next = flush_reg - 3'd1;
          end
        end
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      wait_reg    <= 8'd0;
      flush_reg   <= 3'd0;
      target_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      flush_reg   <= flush_next;
      target_reg  <= target_next;
      timeout_reg <= timeout_next;
    end
  end

  assign state     = state_reg;
  assign target_pc = target_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change after the falling edge and the
// Mealy outputs are sampled 1ns later, well away from the rising edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt, stallD, redirect, imem_ack;
  logic [31:0] redirect_pc;
  logic        imem_req, pc_en, pc_sel, skid_load, skid_use, fetch_en, fetch_flush;
  logic [31:0] target_pc;
  logic [2:0]  state;
  logic        halted, timeout;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.WORD(32), .FLUSH_CYCLES(2), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .stallD(stallD),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_ack(imem_ack),
    .imem_req(imem_req), .pc_en(pc_en), .pc_sel(pc_sel), .target_pc(target_pc),
    .skid_load(skid_load), .skid_use(skid_use), .fetch_en(fetch_en),
    .fetch_flush(fetch_flush), .state(state), .halted(halted), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 0; halt = 0; stallD = 0; redirect = 0;
    imem_ack = 0; redirect_pc = 32'h0;
    #12;
    check("rst_state", 32'(state), 0);
    check("rst_req", 32'(imem_req), 0);
    check("rst_pc_en", 32'(pc_en), 0);
    check("rst_target", target_pc, 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_halted", 32'(halted), 0);
    next_cycle(); reset = 1'b1;

    // Start and continuous fetch
    next_cycle(); start = 1; imem_ack = 1; #1;
    check("idle_state", 32'(state), 0);
    check("idle_pc_en", 32'(pc_en), 0);
    next_cycle(); start = 0; #1;
    check("fetch_state", 32'(state), 1);
    check("fetch_req", 32'(imem_req), 1);
    check("fetch_target", target_pc, 0);
    for (int i = 0; i < 3; i++) begin
      check("fetch_pc_en", 32'(pc_en), 1);
      check("fetch_en", 32'(fetch_en), 1);
      next_cycle(); #1;
    end

    // Decode stall: skid capture then HOLD
    stallD = 1; #1;
    check("stall_skid_load", 32'(skid_load), 1);
    check("stall_pc_en", 32'(pc_en), 1);
    check("stall_fetch_en", 32'(fetch_en), 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      check("hold_state", 32'(state), 2);
      check("hold_skid_use", 32'(skid_use), 1);
      check("hold_fetch_en", 32'(fetch_en), 0);
      check("hold_req", 32'(imem_req), 0);
    end
    next_cycle(); stallD = 0; #1;
    check("unhold_fetch_en", 32'(fetch_en), 1);
    check("unhold_skid_use", 32'(skid_use), 1);
    next_cycle(); #1;
    check("unhold_state", 32'(state), 1);

    // Redirect with no ack
    imem_ack = 0; redirect = 1; redirect_pc = 32'h100; #1;
    check("redir_pc_sel", 32'(pc_sel), 1);
    check("redir_pc_en", 32'(pc_en), 1);
    check("redir_flush", 32'(fetch_flush), 1);
    check("redir_req", 32'(imem_req), 0);
    check("redir_fetch_en", 32'(fetch_en), 0);
    next_cycle(); redirect = 0; #1;
    check("flush_state", 32'(state), 3);
    check("flush_target", target_pc, 32'h100);
    check("flush_flush", 32'(fetch_flush), 1);
    check("flush_req", 32'(imem_req), 0);
    next_cycle(); #1;
    check("postflush_state", 32'(state), 1);
    check("postflush_flush", 32'(fetch_flush), 0);
    check("postflush_req", 32'(imem_req), 1);

    // Back-to-back redirects restart the flush
    imem_ack = 1; redirect = 1; redirect_pc = 32'h180;
    next_cycle(); redirect_pc = 32'h200; #1;
    check("rr1_state", 32'(state), 3);
    check("rr1_target", target_pc, 32'h180);
    next_cycle(); redirect_pc = 32'h300; #1;
    check("rr2_state", 32'(state), 3);
    check("rr2_target", target_pc, 32'h200);
    check("rr2_flush", 32'(fetch_flush), 1);
    check("rr2_fetch_en", 32'(fetch_en), 0);
    next_cycle(); redirect = 0; #1;
    check("rr3_state", 32'(state), 3);
    check("rr3_target", target_pc, 32'h300);
    check("rr3_flush", 32'(fetch_flush), 1);
    next_cycle(); #1;
    check("rr4_state", 32'(state), 1);
    check("rr4_flush", 32'(fetch_flush), 0);
    check("rr4_fetch_en", 32'(fetch_en), 1);

    // Memory timeout after 15 unacknowledged cycles
    for (int i = 0; i < 15; i++) begin
      next_cycle(); imem_ack = 0; #1;
      check("wait_state", 32'(state), 1);
      check("wait_timeout", 32'(timeout), 0);
    end
    next_cycle(); #1;
    check("to_state", 32'(state), 4);
    check("to_timeout", 32'(timeout), 1);
    check("to_halted", 32'(halted), 1);
    check("to_req", 32'(imem_req), 0);
    check("to_target", target_pc, 32'h300);
    start = 1;
    next_cycle(); start = 0; #1;
    check("halt_start_state", 32'(state), 4);
    check("halt_start_halted", 32'(halted), 1);
    #1 reset = 1'b0; #1;
    check("async_rst_state", 32'(state), 0);
    check("async_rst_timeout", 32'(timeout), 0);
    check("async_rst_target", target_pc, 0);
    next_cycle(); reset = 1'b1;

    // halt+start in IDLE, then halt+redirect in FETCH
    next_cycle(); start = 1; halt = 1; imem_ack = 1;
    next_cycle(); start = 0; redirect = 1; redirect_pc = 32'h400; #1;
    check("hs_state", 32'(state), 1);
    check("hr_flush", 32'(fetch_flush), 1);
    check("hr_fetch_en", 32'(fetch_en), 0);
    next_cycle(); redirect = 0; #1;
    check("hr_state", 32'(state), 3);
    check("hr_flush_fetch_en", 32'(fetch_en), 0);
    check("hr_flush_pc_en", 32'(pc_en), 0);
    next_cycle(); #1;
    check("hr_halt_state", 32'(state), 4);
    check("hr_halted", 32'(halted), 1);
    check("hr_halt_target", target_pc, 32'h400);
    check("hr_halt_fetch_en", 32'(fetch_en), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
